instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 135 +++++++++++++
 tb/tb_instr_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Purpose: encodes MIPS mnemonics into 32-bit instruction words and queues them with byte addresses.
// Latency: 1 cycle from an accepted request to the word at the FIFO head when the FIFO was empty.
// Backpressure: in_ready = (count < DEPTH) regardless of out_ready; words wait in the FIFO until out_ready.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_op/in_rs/in_rt/in_rd/in_imm carry the fields
//   out_valid/out_ready   output handshake; out_instr is the FIFO head, out_addr its byte address
//   illegal_cnt           saturating count of dropped illegal requests
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          WORDS     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [7:0]  illegal_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [31:0]   LAST_ADDR = BASE_ADDR + 32'((WORDS - 1) * 4);

  // Mnemonic codes on in_op
  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SUBU = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_LUI  = 4'd6;
  localparam logic [3:0] OP_JAL  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_JR   = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'd10;

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic          accept;
  logic          push;
  logic          pop;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    ill_q, ill_d;

  // Instruction encoder
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_op)
      OP_ADDU: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21};
      OP_SUBU: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h23};
      OP_ORI:  enc_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
      OP_LW:   enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
      OP_SW:   enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
      OP_BEQ:  enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
      OP_LUI:  enc_word = {6'h0F, 5'h00, in_rt, in_imm[15:0]};
      OP_JAL:  enc_word = {6'h03, in_imm};
      OP_J:    enc_word = {6'h02, in_imm};
      OP_JR:   enc_word = {6'h00, in_rs, 15'h0000, 6'h08};
      OP_NOP:  enc_word = 32'h0;
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  // Illegal requests complete the handshake but never occupy a FIFO slot
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;

  assign out_instr   = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign out_addr    = addr_q;
  assign illegal_cnt = ill_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    addr_d = addr_q;
    if (pop) begin
      addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + 32'd4;
    end
    ill_d = ill_q;
    if (accept && !enc_legal && ill_q != 8'hFF) begin
      ill_d = ill_q + 8'd1;
    end
  end

  // Storage needs no reset: out_instr is masked to zero while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      ill_q    <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      ill_q    <= ill_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [25:0] in_imm;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_instr, out_instr2;
  logic [31:0] out_addr, out_addr2;
  logic [7:0]  illegal_cnt, illegal_cnt2;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: queue of expected words, pop count for addressing
  logic [31:0] q[$];
  int          m_pops;
  int          m_ill;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WORDS(4096)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .illegal_cnt(illegal_cnt)
  );

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_addr(out_addr2), .illegal_cnt(illegal_cnt2)
  );

  function automatic logic [31:0] enc_ref(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [25:0] imm);
    logic [31:0] r;
    r = 32'h0;
    case (op)
      0:  r = (rs << 21) | (rt << 16) | (rd << 11) | 32'h21;
      1:  r = (rs << 21) | (rt << 16) | (rd << 11) | 32'h23;
      2:  r = (32'h0D << 26) | (rs << 21) | (rt << 16) | imm[15:0];
      3:  r = (32'h23 << 26) | (rs << 21) | (rt << 16) | imm[15:0];
      4:  r = (32'h2B << 26) | (rs << 21) | (rt << 16) | imm[15:0];
      5:  r = (32'h04 << 26) | (rs << 21) | (rt << 16) | imm[15:0];
      6:  r = (32'h0F << 26) | (rt << 16) | imm[15:0];
      7:  r = (32'h03 << 26) | imm;
      8:  r = (32'h02 << 26) | imm;
      9:  r = (rs << 21) | 32'h08;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input int words);
    return BASE + 32'(4 * (m_pops % words));
  endfunction

  function automatic logic [31:0] exp_head();
    return (q.size() != 0) ? q[0] : 32'h0;
  endfunction

  task automatic drive(input bit v, input int op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm);
    in_valid = v;
    in_op    = 4'(op);
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
  endtask

  task automatic drive_rand_legal();
    drive(1'b1, $urandom_range(0, 10), 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
  endtask

  // Advance one clock; update the model from the driven inputs and its own occupancy
  task automatic step();
    bit acc, pop;
    @(posedge clk);
    pop = out_ready && (q.size() > 0);
    acc = in_valid && (q.size() < DEPTH);
    if (pop) begin
      void'(q.pop_front());
      m_pops++;
    end
    if (acc) begin
      if (in_op <= 4'd10) q.push_back(enc_ref(int'(in_op), in_rs, in_rt, in_rd, in_imm));
      else if (m_ill < 255) m_ill++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_pops = 0;
    m_ill  = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 0, 5'd1, 5'd2, 5'd3, 26'd0);
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", out_instr); else pass_cnt++;
    chk_cnt++; if (out_addr !== BASE) $display("FAIL rst_addr got %h want %h", out_addr, BASE); else pass_cnt++;
    chk_cnt++; if (illegal_cnt !== 8'd0) $display("FAIL rst_ill got %0d want 0", illegal_cnt); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready); else pass_cnt++;
    // A request held across a clock edge during reset must not be taken
    @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_no_accept got %b want 0", out_valid); else pass_cnt++;
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    reset = 1'b1;
    q.delete();
    m_pops = 0;
    m_ill  = 0;
  endtask

  task automatic test_addu();
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 0, 5'd1, 5'd2, 5'd3, 26'd0);
    step();
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL addu_valid got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_instr !== 32'h0022_1821) $display("FAIL addu_instr got %h want 00221821", out_instr); else pass_cnt++;
    chk_cnt++; if (out_addr !== 32'h0000_3000) $display("FAIL addu_addr got %h want 00003000", out_addr); else pass_cnt++;
    out_ready = 1'b1;
    step();
    chk_cnt++; if (out_valid !== 1'b0 || out_instr !== 32'h0)
      $display("FAIL addu_drain got v=%b i=%h want v=0 i=0", out_valid, out_instr); else pass_cnt++;
  endtask

  task automatic test_sequence();
    int          op[5]  = '{2, 6, 4, 7, 9};
    logic [4:0]  rs[5]  = '{5'd0, 5'd0, 5'd29, 5'd0, 5'd31};
    logic [4:0]  rt[5]  = '{5'd1, 5'd1, 5'd8, 5'd0, 5'd0};
    logic [25:0] imm[5] = '{26'h1234, 26'hFFFF, 26'hFFFC, 26'h0000C00, 26'h0};
    logic [31:0] ew[5]  = '{32'h3401_1234, 32'h3C01_FFFF, 32'hAFA8_FFFC, 32'h0C00_0C00, 32'h03E0_0008};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, op[k], rs[k], rt[k], 5'd0, imm[k]);
      step();
      chk_cnt++; if (out_instr !== ew[k] || out_addr !== BASE + 32'(4 * k))
        $display("FAIL seq%0d got %h@%h want %h@%h", k, out_instr, out_addr, ew[k], BASE + 32'(4 * k));
      else pass_cnt++;
    end
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL seq_empty got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] head;
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_rand_legal();
      chk_cnt++; if (in_ready !== (k < DEPTH))
        $display("FAIL bp_ready%0d got %b want %b", k, in_ready, k < DEPTH); else pass_cnt++;
      step();
    end
    head = q[0];
    for (int k = 0; k < 2; k++) begin
      step();
      chk_cnt++; if (out_instr !== head || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got %h rdy=%b want %h rdy=0", k, out_instr, in_ready, head); else pass_cnt++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) drive(1'b1, int'(in_op), in_rs, in_rt, in_rd, in_imm);
      else drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
      chk_cnt++; if (out_instr !== exp_head() || out_addr !== exp_addr(4096) || out_valid !== (q.size() != 0))
        $display("FAIL bp_drain%0d got %h@%h want %h@%h", k, out_instr, out_addr, exp_head(), exp_addr(4096));
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 12, 5'd1, 5'd2, 5'd3, 26'h3FF);
    step();
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ill_novalid got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (illegal_cnt !== 8'd1) $display("FAIL ill_cnt1 got %0d want 1", illegal_cnt); else pass_cnt++;
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, $urandom_range(11, 15), 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
      step();
    end
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    chk_cnt++; if (illegal_cnt !== 8'd255) $display("FAIL ill_sat got %0d want 255", illegal_cnt); else pass_cnt++;
    chk_cnt++; if (out_addr !== BASE) $display("FAIL ill_addr got %h want %h", out_addr, BASE); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] ea[5] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3000};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_rand_legal();
      step();
      chk_cnt++; if (out_addr2 !== ea[k]) $display("FAIL wrap%0d got %h want %h", k, out_addr2, ea[k]); else pass_cnt++;
    end
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    step();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b1;
    drive_rand_legal();
    step();
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_rand_legal();
      step();
    end
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL mid_pre got %b want 1", out_valid); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    chk_cnt++; if (out_valid !== 1'b0 || out_addr !== BASE)
      $display("FAIL mid_async got v=%b a=%h want v=0 a=%h", out_valid, out_addr, BASE); else pass_cnt++;
    q.delete();
    m_pops = 0;
    m_ill  = 0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 0, 5'd4, 5'd5, 5'd6, 26'd0);
    step();
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    chk_cnt++; if (out_instr !== 32'h0085_3021 || out_addr !== BASE)
      $display("FAIL mid_first got %h@%h want 00853021@%h", out_instr, out_addr, BASE); else pass_cnt++;
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0)
        drive(1'b1, $urandom_range(11, 15), 5'($urandom), 5'($urandom), 5'($urandom), 26'($urandom));
      else if ($urandom_range(0, 3) != 0) drive_rand_legal();
      else drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
      step();
      chk_cnt++;
      if (out_valid !== (q.size() != 0) || out_instr !== exp_head() || out_addr !== exp_addr(4096) ||
          in_ready !== (q.size() < DEPTH) || illegal_cnt !== 8'(m_ill) ||
          out_addr2 !== exp_addr(4) || out_instr2 !== exp_head()) begin
        if (bad < 5)
          $display("FAIL rand%0d got v=%b %h@%h/%h ill=%0d want v=%b %h@%h/%h ill=%0d", k, out_valid, out_instr,
                   out_addr, out_addr2, illegal_cnt, q.size() != 0, exp_head(), exp_addr(4096), exp_addr(4), m_ill);
        bad++;
      end else pass_cnt++;
    end
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    m_pops    = 0;
    m_ill     = 0;
    drive(1'b0, 10, 5'd0, 5'd0, 5'd0, 26'd0);
    test_reset();
    test_addu();
    test_sequence();
    test_backpressure();
    test_illegal();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
